nlfsr_core: RTL
===============

// Module: nlfsr_core
// PURPOSE
//   State register of the NLFSR generator. Loads a seed, then shifts once per cycle,
//   inserting the feedback bit computed combinationally by the downstream tap/XOR stage
//   from `register`. Runs for a bounded step count or until the state returns to the
//   seed. Reports the cycle count, so the host measures the period of a candidate
//   tap/coefficient set.
// PARAMETERS
//   SIZE   32  NLFSR width in bits; >= 20, because tap indices reach bit 19
//   CNT_W  32  width of the step limit and cycle counter
// PORTS
//   clk           in   1      single clock, all logic on rising edge
//   res           in   1      synchronous, active-high reset
//   start         in   1      request a run; sampled only in IDLE
//   seed          in   SIZE   initial state; sampled on the accepted start
//   steps         in   CNT_W  max shifts for the run; sampled on the accepted start
//   feedback      in   1      new-bit input from tap/XOR stage (combinational from register)
//   register      out  SIZE   current NLFSR state; drives the tap/XOR stage
//   xor_start     out  1      tap-stage enable; equals busy
//   out_bit       out  1      keystream bit = register[0]
//   busy          out  1      high in RUN
//   done          out  1      one-cycle pulse in DONE
//   period_found  out  1      last run ended with state == seed; held until next accepted start
//   zero_seed     out  1      last run rejected an all-zero seed; held until next accepted start
//   cycle_count   out  CNT_W  shifts done in last/current run; held after DONE
// BEHAVIOUR
//   Reset: state = IDLE. All outputs are 0, including register, cycle_count and seed_q.
//     Reset during RUN aborts the run with no done pulse.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start, at the same edge:
//     - register <= seed, seed_q <= seed, steps_q <= steps
//     - cycle_count <= 0; period_found and zero_seed <= 0
//     - next state:
//       - seed == 0: zero_seed <= 1, go to DONE (no shifts)
//       - else steps == 0: go to DONE (no shifts)
//       - else: go to RUN
//   RUN: each edge:
//     - nxt = {feedback, register[SIZE-1:1]}; register <= nxt
//     - cycle_count <= cycle_count + 1
//     - nxt == seed_q: period_found <= 1, go to DONE. This has priority over the limit.
//     - else cycle_count + 1 == steps_q: go to DONE, period_found stays 0.
//     - The counter saturates only through steps_q, so it never wraps within a run.
//   DONE: done = 1 for exactly one cycle. Next state is IDLE. A start in DONE is ignored.
//   start while busy or in DONE: ignored. seed/steps changes after acceptance have no effect.
//   Latency: start accepted at edge k, then busy = 1 from k to k+N, where N = shifts run;
//     done is high in the cycle after edge k+N.
//   register holds its final value after DONE until the next accepted start.
//   feedback is used only in RUN; the tap stage must see xor_start = 1 during RUN.
// TESTING
//   1. Rotation: bench feedback = register[0], seed = 32'h1, steps = 100
//      -> 32 shifts, period_found = 1, cycle_count = 32, register = 32'h1, one done pulse.
//   2. Limit: feedback = 0, seed = 32'h8000_0000, steps = 5
//      -> register = 32'h0400_0000, period_found = 0, cycle_count = 5.
//   3. Degenerate: seed = 0 -> done 1 cycle after start, zero_seed = 1, cycle_count = 0.
//      steps = 0, seed = 1 -> done, cycle_count = 0, period_found = 0.
//   4. Fixed point: feedback = 1, seed = 32'hFFFF_FFFF, steps = 10
//      -> period_found = 1, cycle_count = 1.
//   5. start pulsed during RUN, and with a new seed in DONE
//      -> ignored; results match the first run exactly.
//   6. res asserted at shift 7 of test 1
//      -> next cycle: IDLE, register = 0, busy = 0, no done.
//      A new start then completes normally.

Source files
------------

// File: rtl/nlfsr_core_if.sv
// Host/tap-stage bundle for the NLFSR state register.
// master: host and tap/XOR stage side; slave: nlfsr_core.
interface nlfsr_core_if #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 32
);
  logic             start;
  logic [SIZE-1:0]  seed;
  logic [CNT_W-1:0] steps;
  logic             feedback;
  logic [SIZE-1:0]  register;
  logic             xor_start;
  logic             out_bit;
  logic             busy;
  logic             done;
  logic             period_found;
  logic             zero_seed;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, seed, steps, feedback,
    input  register, xor_start, out_bit, busy, done,
           period_found, zero_seed, cycle_count
  );

  modport slave (
    input  start, seed, steps, feedback,
    output register, xor_start, out_bit, busy, done,
           period_found, zero_seed, cycle_count
  );
endinterface

// File: rtl/nlfsr_core.sv
// NLFSR state register: loads a seed, shifts in the external feedback bit once
// per cycle, and stops on a step limit or when the state returns to the seed.
// The shift count of the finished run is reported so the host can measure the
// period of a tap set. SIZE must be at least 20 (tap stage reads bit 19).
module nlfsr_core #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          res,
  nlfsr_core_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SIZE-1:0]  r_register;
  logic [SIZE-1:0]  r_seed_q;
  logic [CNT_W-1:0] r_steps_q;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_busy;
  logic             r_done;
  logic             r_period_found;
  logic             r_zero_seed;

  logic [SIZE-1:0]  w_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  // New bit enters at the MSB; the LSB leaves as the keystream bit.
  assign w_nxt     = {bus.feedback, r_register[SIZE-1:1]};
  assign w_cnt_inc = r_cycle_count + CNT_W'(1);

  // Control FSM with registered status outputs; seed match wins over the limit.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state        <= S_IDLE;
      r_register     <= '0;
      r_seed_q       <= '0;
      r_steps_q      <= '0;
      r_cycle_count  <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_period_found <= 1'b0;
      r_zero_seed    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_register     <= bus.seed;
            r_seed_q       <= bus.seed;
            r_steps_q      <= bus.steps;
            r_cycle_count  <= '0;
            r_period_found <= 1'b0;
            r_zero_seed    <= 1'b0;
            if (bus.seed == '0) begin
              // An all-zero state can never leave zero under most tap sets.
              r_zero_seed <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else if (bus.steps == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_register    <= w_nxt;
          r_cycle_count <= w_cnt_inc;
          if (w_nxt == r_seed_q) begin
            r_period_found <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
            r_state        <= S_DONE;
          end else if (w_cnt_inc == r_steps_q) begin
            // Counter stops here, so it can never wrap inside a run.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // start is deliberately ignored here.
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.register     = r_register;
  assign bus.xor_start    = r_busy;
  assign bus.out_bit      = r_register[0];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.period_found = r_period_found;
  assign bus.zero_seed    = r_zero_seed;
  assign bus.cycle_count  = r_cycle_count;

endmodule
